// File: rtl/data_checker.sv
// Sink-side checker for an incrementing test stream: locks on, then counts sequence errors and accepted words.
// Latency: every output is registered and reflects a beat on the cycle after that beat is sampled.
// Backpressure: ch_ready is always high after reset. When CHECKER_STALL_EN is defined, an LFSR stalls about 25% of cycles.
module data_checker #(
    parameter int DATA_W      = 32,
    parameter int ERR_CNT_W   = 16,
    parameter int LOCK_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    ch_data,
    input  logic                 ch_valid,
    output logic                 ch_ready,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          word_cnt
);

    localparam int RUN_W = $clog2(LOCK_THRESH + 1);
    localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(LOCK_THRESH);

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [DATA_W-1:0]      exp_word, exp_word_nxt;
    logic [RUN_W-1:0]       good_run, good_run_nxt;
    logic                   locked_nxt, err_pulse_nxt;
    logic [ERR_CNT_W-1:0]   err_cnt_nxt;
    logic [31:0]            word_cnt_nxt;
    logic                   beat, match;

    assign beat  = ch_valid & ch_ready;
    assign match = (ch_data == exp_word);

`ifdef CHECKER_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // x^16+x^14+x^13+x^11+1 taps, shifting towards bit 0
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Free-running LFSR; ready stalls whenever the two low bits are both set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= 16'hACE1;
            ch_ready <= 1'b0;
        end else begin
            lfsr     <= {lfsr_fb, lfsr[15:1]};
            ch_ready <= ~(lfsr[0] & lfsr[1]);
        end
    end
`else
    // Ready rises on the first edge out of reset and then stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ch_ready <= 1'b0;
        else        ch_ready <= 1'b1;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEEK;
            exp_word  <= '0;
            good_run  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            exp_word  <= exp_word_nxt;
            good_run  <= good_run_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err_cnt   <= err_cnt_nxt;
            word_cnt  <= word_cnt_nxt;
        end
    end

    // Next-state logic: clr has priority over a beat, and without a beat everything holds except the pulse
    always_comb begin
        state_nxt     = state;
        exp_word_nxt  = exp_word;
        good_run_nxt  = good_run;
        locked_nxt    = locked;
        err_pulse_nxt = 1'b0;
        err_cnt_nxt   = err_cnt;
        word_cnt_nxt  = word_cnt;
        if (clr) begin
            state_nxt    = SEEK;
            exp_word_nxt = '0;
            good_run_nxt = '0;
            locked_nxt   = 1'b0;
            err_cnt_nxt  = '0;
            word_cnt_nxt = '0;
        end else if (beat) begin
            word_cnt_nxt = word_cnt + 32'd1;
            case (state)
                SEEK: begin
                    exp_word_nxt = ch_data + DATA_W'(1);
                    good_run_nxt = RUN_W'(1);
                    state_nxt    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        exp_word_nxt = exp_word + DATA_W'(1);
                        good_run_nxt = good_run + RUN_W'(1);
                        if (good_run + RUN_W'(1) == THRESH_R) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        // Resync silently while still acquiring
                        exp_word_nxt = ch_data + DATA_W'(1);
                        good_run_nxt = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        exp_word_nxt = exp_word + DATA_W'(1);
                    end else begin
                        err_pulse_nxt = 1'b1;
                        if (!(&err_cnt)) err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
                        exp_word_nxt  = ch_data + DATA_W'(1);
                        good_run_nxt  = RUN_W'(1);
                        locked_nxt    = 1'b0;
                        state_nxt     = ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = SEEK;
                end
            endcase
        end
    end

endmodule
